// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: start/key handshake, stage enables/valids and status of the AES round sequencer.
interface aes_round_sequencer_if;
    logic       start;
    logic       key_ready;
    logic       sub_valid;
    logic       shift_valid;
    logic       mix_valid;
    logic       ark_valid;
    logic       sub_en;
    logic       shift_en;
    logic       mix_en;
    logic       ark_en;
    logic [3:0] round_idx;
    logic [1:0] ark_src_sel;
    logic       state_load;
    logic       busy;
    logic       done;
    logic       timeout_err;

    modport slave (
        input  start, key_ready, sub_valid, shift_valid, mix_valid, ark_valid,
        output sub_en, shift_en, mix_en, ark_en, round_idx, ark_src_sel,
               state_load, busy, done, timeout_err
    );

    modport master (
        output start, key_ready, sub_valid, shift_valid, mix_valid, ark_valid,
        input  sub_en, shift_en, mix_en, ark_en, round_idx, ark_src_sel,
               state_load, busy, done, timeout_err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: steps an AES-128 block through its 40 stage operations,
// with a per-stage watchdog that abandons the block if a stage stalls.
module aes_round_sequencer #(
    parameter int STAGE_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    aes_round_sequencer_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, WAIT_KEY, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE} state_e;

    state_e     state_q, nxt;
    logic [3:0] round_q, wd_q;
    logic [1:0] src_q;
    logic       sub_en_q, shift_en_q, mix_en_q, ark_en_q;
    logic       state_load_q, busy_q, done_q, timeout_err_q;
    logic       act_valid, last_round;

    always_comb begin
        last_round = round_q == 4'd10;
        act_valid  = (state_q == SUB)   ? bus.sub_valid :
                     (state_q == SHIFT) ? bus.shift_valid :
                     (state_q == MIX)   ? bus.mix_valid :
                     (state_q == INIT_ARK || state_q == ARK) ? bus.ark_valid : 1'b0;
        nxt        = (state_q == INIT_ARK) ? SUB :
                     (state_q == SUB)      ? SHIFT :
                     (state_q == SHIFT)    ? (last_round ? ARK : MIX) :
                     (state_q == MIX)      ? ARK :
                     last_round            ? DONE : SUB;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            round_q       <= '0;
            wd_q          <= '0;
            src_q         <= '0;
            sub_en_q      <= 1'b0;
            shift_en_q    <= 1'b0;
            mix_en_q      <= 1'b0;
            ark_en_q      <= 1'b0;
            state_load_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            sub_en_q      <= 1'b0;
            shift_en_q    <= 1'b0;
            mix_en_q      <= 1'b0;
            ark_en_q      <= 1'b0;
            state_load_q  <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    round_q <= '0;
                    busy_q  <= 1'b1;
                    if (bus.key_ready) begin
                        state_q  <= INIT_ARK;
                        ark_en_q <= 1'b1;
                        src_q    <= 2'd0;
                        wd_q     <= '0;
                    end else begin
                        state_q <= WAIT_KEY;
                    end
                end
                WAIT_KEY: if (bus.key_ready) begin
                    state_q  <= INIT_ARK;
                    ark_en_q <= 1'b1;
                    src_q    <= 2'd0;
                    wd_q     <= '0;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    // a valid in the watchdog's final cycle still wins over the timeout
                    if (act_valid) begin
                        state_q      <= nxt;
                        wd_q         <= '0;
                        state_load_q <= state_q == INIT_ARK || state_q == ARK;
                        sub_en_q     <= nxt == SUB;
                        shift_en_q   <= nxt == SHIFT;
                        mix_en_q     <= nxt == MIX;
                        ark_en_q     <= nxt == ARK;
                        done_q       <= nxt == DONE;
                        if (nxt == SUB) round_q <= round_q + 4'd1;
                        if (nxt == ARK) src_q <= (state_q == MIX) ? 2'd1 : 2'd2;
                    end else if (wd_q == 4'(STAGE_TIMEOUT - 1)) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        wd_q          <= '0;
                    end else begin
                        wd_q <= wd_q + 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.sub_en      = sub_en_q;
    assign bus.shift_en    = shift_en_q;
    assign bus.mix_en      = mix_en_q;
    assign bus.ark_en      = ark_en_q;
    assign bus.round_idx   = round_q;
    assign bus.ark_src_sel = src_q;
    assign bus.state_load  = state_load_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: drives whole blocks through the sequencer with fixed and
// random stage delays and checks order, rounds, timing, watchdog and reset behaviour.
module tb_aes_round_sequencer;
    localparam int STO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    aes_round_sequencer_if bus ();

    aes_round_sequencer #(.STAGE_TIMEOUT(STO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_valids();
        bus.sub_valid   = 1'b0;
        bus.shift_valid = 1'b0;
        bus.mix_valid   = 1'b0;
        bus.ark_valid   = 1'b0;
    endtask

    function automatic logic [13:0] outs();
        return {bus.sub_en, bus.shift_en, bus.mix_en, bus.ark_en, bus.round_idx,
                bus.ark_src_sel, bus.state_load, bus.busy, bus.done, bus.timeout_err};
    endfunction

    // Stage codes: 0 SubBytes, 1 ShiftRows, 2 MixColumns, 3 AddRoundKey.
    function automatic int exp_stage(int i);
        if (i == 0) return 3;
        if (i >= 37) return (i == 39) ? 3 : i - 37;
        return (i - 1) % 4;
    endfunction

    function automatic int exp_round(int i);
        return (i == 0) ? 0 : (i >= 37) ? 10 : (i - 1) / 4 + 1;
    endfunction

    // One block; fixed_d < 0 picks random delays, kill_idx withholds that stage's valid,
    // rst_idx pulls reset at that enable, spur injects sub_valid and start during MIX.
    task automatic run_block(input int fixed_d, input int key_wait, input int kill_idx,
                             input int rst_idx, input bit spur);
        int cyc, n_en, n_ld, n_done, n_terr, done_cyc, terr_cyc, exp_cyc, exp_ld;
        int pend_s, pend_c, s, d, extra;
        logic [3:0] ens;
        bit fin;
        n_en = 0; n_ld = 0; n_done = 0; n_terr = 0; exp_ld = 0; extra = 0;
        done_cyc = -1; terr_cyc = -1; exp_cyc = key_wait; pend_s = -1; pend_c = 0; fin = 1'b0;
        bus.key_ready = (key_wait == 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        cyc = 0;
        while (1) begin
            clear_valids();
            bus.start = 1'b0;
            if (key_wait > 0 && cyc == key_wait - 1) bus.key_ready = 1'b1;
            ens = {bus.ark_en, bus.mix_en, bus.shift_en, bus.sub_en};
            if (cyc < key_wait) chk("wait_busy_no_en", {ens, bus.busy}, 5'b00001);
            if (ens != 4'd0) begin
                chk("one_hot_en", $countones(ens), 1);
                s = ens[3] ? 3 : ens[2] ? 2 : ens[1] ? 1 : 0;
                chk($sformatf("stage_%0d", n_en), s, exp_stage(n_en));
                chk($sformatf("round_%0d", n_en), bus.round_idx, exp_round(n_en));
                if (s == 3)
                    chk($sformatf("src_%0d", n_en), bus.ark_src_sel,
                        exp_round(n_en) == 0 ? 0 : exp_round(n_en) == 10 ? 2 : 1);
                if (n_en == rst_idx) begin
                    rst = 1'b0;
                    #1;
                    chk("rst_all_zero", outs(), 0);
                    clear_valids();
                    step();
                    chk("rst_held_zero", outs(), 0);
                    rst = 1'b1;
                    return;
                end
                d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 14));
                if (n_en != kill_idx) begin
                    pend_s = s;
                    pend_c = d;
                    exp_cyc += d + 1;
                    if (s == 3) exp_ld++;
                end else begin
                    exp_cyc += STO;
                end
                if (spur && s == 2) begin
                    bus.sub_valid = 1'b1;
                    bus.start = 1'b1;
                end
                n_en++;
            end
            if (pend_s >= 0) begin
                if (pend_c == 0) begin
                    bus.sub_valid   = pend_s == 0;
                    bus.shift_valid = pend_s == 1;
                    bus.mix_valid   = pend_s == 2;
                    bus.ark_valid   = pend_s == 3;
                    pend_s = -1;
                end else begin
                    pend_c--;
                end
            end
            n_ld += int'(bus.state_load);
            if (bus.done) begin n_done++; done_cyc = cyc; fin = 1'b1; end
            if (bus.timeout_err) begin n_terr++; terr_cyc = cyc; fin = 1'b1; end
            if (fin || cyc >= 3000) break;
            step();
            cyc++;
        end
        chk("bounded_wait", fin, 1);
        clear_valids();
        repeat (3) begin
            step();
            extra += int'({bus.ark_en, bus.mix_en, bus.shift_en, bus.sub_en} != 4'd0);
            n_done += int'(bus.done);
            n_terr += int'(bus.timeout_err);
            n_ld += int'(bus.state_load);
        end
        chk("idle_after", bus.busy, 0);
        chk("no_en_after", extra, 0);
        chk("load_count", n_ld, exp_ld);
        if (kill_idx < 0) begin
            chk("en_count", n_en, 40);
            chk("done_count", n_done, 1);
            chk("done_cycle", done_cyc, exp_cyc);
            chk("no_timeout", n_terr, 0);
            chk("round_after_done", bus.round_idx, 10);
        end else begin
            chk("en_count_to", n_en, kill_idx + 1);
            chk("no_done_on_to", n_done, 0);
            chk("timeout_count", n_terr, 1);
            chk("timeout_cycle", terr_cyc, exp_cyc);
            chk("round_after_to", bus.round_idx, exp_round(kill_idx));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key_ready = 1'b1;
        clear_valids();
        repeat (3) step();
        chk("reset_state", outs(), 0);
        rst = 1'b1;
        run_block(1, 0, -1, -1, 1'b0);
        step();
        run_block(1, 5, -1, -1, 1'b0);
        step();
        run_block(1, 0, 11, -1, 1'b0);
        step();
        run_block(1, 0, -1, 22, 1'b0);
        run_block(1, 0, -1, -1, 1'b0);
        step();
        run_block(2, 0, -1, -1, 1'b1);
        run_block(0, 0, -1, -1, 1'b0);
        run_block(14, 0, -1, -1, 1'b0);
        repeat (3) run_block(-1, 0, -1, -1, 1'b1);
        run_block(-1, 3, 30, -1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter STAGE_TIMEOUT, default 15: maximum wait cycles for an active stage's valid after its enable.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request to encrypt one block; sampled only in IDLE.
REQ-005 key_ready  in  1  round-key schedule is available for all rounds.
REQ-006 sub_valid, shift_valid, mix_valid, ark_valid  in  1 each  completion pulses from the SubBytes, ShiftRows, MixColumns and AddRoundKey stages.
REQ-007 sub_en, shift_en, mix_en, ark_en  out  1 each  stage enables.
REQ-008 round_idx  out  4  current round number 0..10, used as the round-key select.
REQ-009 ark_src_sel  out  2  AddRoundKey input mux: 0 = plaintext, 1 = MixColumns output, 2 = ShiftRows output; 3 is never driven.
REQ-010 state_load  out  1  capture the AddRoundKey result into the state register.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse when the ciphertext is valid in the state register.
REQ-013 timeout_err  out  1  one-cycle pulse when a stage watchdog expires.

Function
REQ-014 FSM states: IDLE, WAIT_KEY, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE; all outputs are registered.
REQ-015 IDLE transitions:
- start=1 and key_ready=1: go to INIT_ARK.
- start=1 and key_ready=0: go to WAIT_KEY.
- Both cases load round_idx=0.
REQ-016 WAIT_KEY goes to INIT_ARK on the first cycle key_ready=1, and waits indefinitely otherwise.
REQ-017 In each stage state, the matching *_en is high for exactly the first cycle of that state (issue cycle); at most one *_en is high in any cycle.
REQ-018 The active stage's valid is accepted in any cycle of its state, including the issue cycle; the FSM advances on the edge that samples it.
REQ-019 Valid pulses from non-active stages are ignored with no side effects.
REQ-020 State sequence:
- INIT_ARK -> SUB.
- SUB -> SHIFT.
- SHIFT -> MIX when round_idx<10; SHIFT -> ARK when round_idx=10.
- MIX -> ARK.
- ARK -> DONE when round_idx=10; ARK -> SUB otherwise.
REQ-021 round_idx increments by 1 on the edge leaving INIT_ARK or leaving ARK with round_idx<10; it never exceeds 10.
REQ-022 ark_src_sel values:
- INIT_ARK: 0.
- ARK with round_idx 1..9: 1.
- ARK with round_idx=10: 2.
- Held otherwise.
REQ-023 state_load pulses for one cycle, coincident with the edge at which ark_valid is accepted.
REQ-024 DONE lasts one cycle with done=1, then returns to IDLE; round_idx holds 10 until the next start.
REQ-025 Latency with 1-cycle-registered stages (valid the cycle after en): 40 stage steps x 2 cycles, so done=1 in the cycle after the 80th rising edge following the edge that sampled start (key_ready=1).
REQ-026 start while busy=1 is ignored, and no request is queued.
REQ-027 Watchdog behaviour:
- A 4-bit counter clears on every stage-state entry and increments each cycle without the active valid.
- Reaching STAGE_TIMEOUT without a valid: timeout_err pulses for one cycle and the FSM goes to IDLE.
- On a timeout, done is not asserted and round_idx holds.
REQ-028 A valid sampled in the same cycle the counter reaches STAGE_TIMEOUT wins: the FSM advances and no error is raised.

Reset
REQ-029 rst=0 forces the following immediately, including mid-encryption:
- State IDLE, round_idx=0, ark_src_sel=0, watchdog counter=0.
- All *_en, state_load, busy, done and timeout_err at 0.
REQ-030 After rst deasserts, the first start is accepted on the next rising edge.

Verification
REQ-031 Nominal: key_ready=1, stages valid 1 cycle after en, start pulse -> 40 enables in order ARK, (SUB, SHIFT, MIX, ARK)x9, SUB, SHIFT, ARK; 11 state_load pulses; done at cycle 80; FIPS-197 App. B block yields 3925841d02dc09fbdc118597196a0b32.
REQ-032 start with key_ready=0 held 5 cycles -> busy=1, no en for 5 cycles, then ark_en; done 5 cycles later than REQ-025.
REQ-033 mix_valid withheld in round 3 -> timeout_err pulse after 15 cycles, state IDLE, round_idx=3, no done.
REQ-034 rst low during round 6 SHIFT -> all outputs 0 at once; a new start after release completes normally in 80 cycles.
REQ-035 Spurious sub_valid during MIX, and start during busy -> no state, round_idx or output change.
REQ-036 Random stage delays 0..14 cycles -> enable order and round_idx as REQ-031, no timeout_err, done exactly once.
